uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receive stage of the UART: oversamples the raw rx pin and deserialises frames into bytes.
- Produces rx_data plus a one-cycle rx_done strobe, consumed directly by the Avalon UART slave's rx_data register.
- Generates its own oversampling tick from the software-programmed clk_div divisor.
- Runs entirely in the system clock domain; no derived clocks.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, ticks per bit period; must be an even number, at least 4.
- DIV_W, 32, width of the clk_div input.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- clk_div, in, DIV_W, tick period in clk cycles minus 1. A value of 0 gives a tick every cycle.
- rx, in, 1, asynchronous serial line; idles high.
- rx_data, out, DATA_BITS, last received byte.
- rx_done, out, 1, one-cycle strobe: rx_data/frame_err updated.
- frame_err, out, 1, stop bit of the last frame was sampled low.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk). Reset reset_n is synchronous and active-low.
- Reset values:
  - rx_data=0, rx_done=0, frame_err=0, busy=0.
  - State=IDLE; tick and sample counters=0.
  - Both synchroniser flops=1.
- Synchroniser: rx passes through a 2-flop synchroniser; the FSM only sees rx_s.
- Tick generator:
  - Counter increments each clk.
  - When count >= clk_div: tick=1 and count clears. Using >= keeps a mid-count clk_div decrease safe.
  - Counter is held at 0 in IDLE, so ticks are phase-aligned to start-bit detection.
  - clk_div changing mid-frame is a software error; the FSM stays consistent but the data is undefined.
- FSM (sample counter scnt counts ticks):
  - IDLE: rx_s==0 -> START, scnt=0.
  - START: on tick with scnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 -> DATA, scnt=0, bit index=0.
    - rx_s==1 -> IDLE (false start, no strobe).
  - DATA: on tick with scnt==OVERSAMPLE-1:
    - Shift rx_s into shift register MSB (LSB-first line order), scnt=0.
    - After DATA_BITS samples -> STOP (or PARITY when the feature is enabled).
  - STOP: on tick with scnt==OVERSAMPLE-1:
    - Load rx_data from the shift register, pulse rx_done, frame_err = ~rx_s.
    - rx_s==1 -> IDLE. rx_s==0 -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. No strobe while waiting.
- Output timing and holding:
  - rx_done is high for exactly the single cycle after the clk edge that samples the stop bit.
  - rx_data and frame_err hold their values until the next rx_done.
- Back-to-back frames: a start bit immediately after the stop-bit midpoint is detected. IDLE is entered the same cycle rx_done pulses.
- Reset mid-frame: the synchronous reset aborts the frame. No rx_done is issued; outputs take reset values on the next edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds input parity_odd (1 bit) and output parity_err (1 bit, reset 0).
  - Adds a PARITY state between DATA and STOP, sampled at bit mid like data.
  - parity_err = XOR(data bits, parity bit) != parity_odd. It updates with rx_done and holds until the next rx_done.
- When undefined: frames are 8N1; neither port nor the PARITY state exists.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the default DATA_BITS and OVERSAMPLE.
- One sub-module is natural: uart_baud_tick (clk_div counter producing tick, with a clear input driven by the FSM while in IDLE). The TX side will reuse it.

Test Plan:
- Nominal 8N1: clk_div=0 (bit=16 clks), frame 0xA5, stop=1 -> exactly one rx_done pulse; rx_data=0xA5, frame_err=0, busy back to 0.
- Glitch: rx low 4 clks, then high -> no rx_done; busy returns 0 within 12 clks.
- Framing error: 0x3C with stop=0, then rx held low 40 clks -> rx_done once, rx_data=0x3C, frame_err=1. No second strobe until rx goes high and a new frame arrives.
- Divider and back-to-back: clk_div=3 (bit=64 clks), frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, rx_data 0x00 then 0xFF, frame_err=0.
- Mid-frame reset: reset_n=0 for 1 cycle during data bit 3 -> all outputs 0, no strobe. The next full frame 0x5A is received correctly.
- Parity (UART_RX_PARITY_EN): parity_odd=0, data 0x07, parity bit 0 -> rx_done, parity_err=1; repeat with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
// Pure declarations; no latency, no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } uart_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: programmed divisor and serial pin in, received byte and status out.
// UART_RX_PARITY_EN adds parity_odd / parity_err.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS,
    parameter int DIV_W     = 32
) ();
    logic [DIV_W-1:0]     clk_div;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;

    modport slave  (input  clk_div, rx, parity_odd,
                    output rx_data, rx_done, frame_err, busy, parity_err);
    modport master (output clk_div, rx, parity_odd,
                    input  rx_data, rx_done, frame_err, busy, parity_err);
`else
    modport slave  (input  clk_div, rx,
                    output rx_data, rx_done, frame_err, busy);
    modport master (output clk_div, rx,
                    input  rx_data, rx_done, frame_err, busy);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: tick every clk_div+1 clocks, combinational from the count register.
// No backpressure; clear holds the count at 0 so the first tick lands clk_div+1 cycles after release.
module uart_baud_tick #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    // >= rather than == so lowering clk_div mid-count cannot skip the wrap
    assign tick = !clear && (cnt >= clk_div);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt <= '0;
        end else if (cnt >= clk_div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver; rx_done strobes one cycle after the clock edge sampling mid stop bit.
// No backpressure: each byte is presented once; UART_RX_PARITY_EN adds a parity bit before stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DIV_W      = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_rx_if.slave bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_END  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BI_LAST = BW'(DATA_BITS - 1);

    uart_state_t          state, state_n;
    logic [SW-1:0]        scnt, scnt_n;
    logic [BW-1:0]        bidx, bidx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 done_q, done_n;
    logic                 ferr_q, ferr_n;
    logic                 rx_m, rx_s;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_n;
    logic                 perr_q, perr_n;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == S_IDLE),
        .clk_div (bus.clk_div),
        .tick    (tick)
    );

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        data_n  = data_q;
        done_n  = 1'b0;
        ferr_n  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
        perr_n  = perr_q;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    scnt_n  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (scnt == SC_MID) begin
                        scnt_n  = '0;
                        bidx_n  = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (scnt == SC_END) begin
                        scnt_n  = '0;
                        // line order is LSB first, so new bits enter at the top
                        shreg_n = DATA_BITS'({rx_s, shreg} >> 1);
                        bidx_n  = bidx + BW'(1);
                        if (bidx == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (scnt == SC_END) begin
                        scnt_n  = '0;
                        par_n   = rx_s;
                        state_n = S_STOP;
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (scnt == SC_END) begin
                        scnt_n  = '0;
                        data_n  = shreg;
                        done_n  = 1'b1;
                        ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_n  = ((^shreg) ^ par_q) != bus.parity_odd;
`endif
                        state_n = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            scnt   <= '0;
            bidx   <= '0;
            shreg  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q  <= 1'b0;
            perr_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            scnt   <= scnt_n;
            bidx   <= bidx_n;
            shreg  <= shreg_n;
            data_q <= data_n;
            done_q <= done_n;
            ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q  <= par_n;
            perr_q <= perr_n;
`endif
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif
endmodule
